hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer.sv | 138 +++++++++++++
 tb/tb_hazard_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: post-reset clear, load-use bubbles, branch flushes
// and multi-cycle MADDU holds, plus a saturating stall-cycle counter.
//
// state      | meaning
// S_INIT     | post-reset pipeline clear, all registers flushed and held
// S_RUN      | normal issue; load-use and branch handled combinationally
// S_MUL_WAIT | MADDU occupying EX, front of pipe held until done or abort
module hazard_sequencer #(
  parameter int MUL_LAT  = 4,
  parameter int INIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_maddu_start,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mul_busy,
  output logic        mul_done,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] INIT_LOAD = 2'(INIT_CYC - 1);
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MUL_WAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] init_cnt, init_cnt_nxt;
  logic [3:0] mul_cnt, mul_cnt_nxt;
  logic       load_use;
  logic       rt_used;

  // rt is only a true source for R-type, MUL (28), BEQ and SW
  assign rt_used  = (id_opcode == 6'd0) || (id_opcode == 6'd28) ||
                    (id_opcode == 6'd4) || (id_opcode == 6'd43);
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_used));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_INIT;
      init_cnt <= INIT_LOAD;
      mul_cnt  <= 4'd0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      mul_cnt  <= mul_cnt_nxt;
    end
  end

  // MUL_WAIT ends on the cycle the counter steps down to zero, giving
  // MUL_LAT-1 cycles of residency after the load of MUL_LAT-1
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    mul_cnt_nxt  = mul_cnt;
    case (state)
      S_INIT: begin
        if (init_cnt == 2'd0) state_nxt = S_RUN;
        else                  init_cnt_nxt = init_cnt - 2'd1;
      end
      S_RUN: begin
        if (!branch_taken && ex_maddu_start) begin
          state_nxt   = S_MUL_WAIT;
          mul_cnt_nxt = MUL_LOAD;
        end
      end
      S_MUL_WAIT: begin
        if (branch_taken) begin
          state_nxt   = S_RUN;
          mul_cnt_nxt = 4'd0;
        end else if (mul_cnt <= 4'd1) begin
          state_nxt   = S_RUN;
          mul_cnt_nxt = 4'd0;
        end else begin
          mul_cnt_nxt = mul_cnt - 4'd1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    exmem_flush = 1'b1;
    mul_busy    = 1'b0;
    mul_done    = 1'b0;
    case (state)
      S_RUN: begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = branch_taken;
        idex_flush  = branch_taken;
        exmem_flush = branch_taken;
        if (!branch_taken && !ex_maddu_start && load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        mul_busy    = 1'b1;
        pc_en       = branch_taken;
        ifid_en     = branch_taken;
        idex_en     = branch_taken;
        ifid_flush  = branch_taken;
        idex_flush  = branch_taken;
        exmem_flush = branch_taken;
        mul_done    = !branch_taken && (mul_cnt <= 4'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if ((state != S_INIT) && !pc_en && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus random traffic, each
// cycle compared with a cycles-remaining reference model.
module tb_hazard_sequencer;
  localparam int MUL_LAT  = 4;
  localparam int INIT_CYC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_memread, ex_maddu_start, branch_taken;
  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
  logic        mul_busy, mul_done;
  logic [15:0] stall_cnt;
  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;
  int m_init_left, m_mul_left, m_stall;
  logic [5:0] ops [6] = '{6'd0, 6'd28, 6'd4, 6'd43, 6'd35, 6'd2};

  hazard_sequencer #(.MUL_LAT(MUL_LAT), .INIT_CYC(INIT_CYC)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_maddu_start(ex_maddu_start),
    .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .mul_busy(mul_busy), .mul_done(mul_done),
    .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
                mul_busy, mul_done};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init_left = INIT_CYC;
    m_mul_left  = 0;
    m_stall     = 0;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] xrt, input logic ms,
                        input logic br);
    id_opcode = op; id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = xrt;
    ex_maddu_start = ms; branch_taken = br;
  endtask

  task automatic idle();
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);
  endtask

  // Expected outputs: {pc,ifid,idex enables, ifid,idex,exmem flushes, busy, done}
  task automatic do_cycle(input string tag);
    logic [7:0] exp;
    logic       lu;
    bit         stall;
    @(negedge clk);
    lu = ex_memread && ex_rt != 0 &&
         (ex_rt == id_rs ||
          (ex_rt == id_rt && (id_opcode == 0 || id_opcode == 28 ||
                              id_opcode == 4 || id_opcode == 43)));
    stall = 0;
    if (m_init_left > 0) exp = 8'b000_111_00;
    else if (m_mul_left > 0) begin
      if (branch_taken) exp = 8'b111_111_10;
      else begin
        exp   = {6'b000_000, 1'b1, 1'(m_mul_left == 1)};
        stall = 1;
      end
    end
    else if (branch_taken)   exp = 8'b111_111_00;
    else if (ex_maddu_start) exp = 8'b111_000_00;
    else if (lu) begin
      exp   = 8'b001_010_00;
      stall = 1;
    end
    else exp = 8'b111_000_00;
    chk({tag, " ctl"}, {8'h00, ctl}, {8'h00, exp});
    chk({tag, " stall_cnt"}, stall_cnt, 16'(m_stall));
    @(posedge clk);
    if (m_init_left > 0) m_init_left--;
    else if (m_mul_left > 0) m_mul_left = branch_taken ? 0 : m_mul_left - 1;
    else if (!branch_taken && ex_maddu_start) m_mul_left = MUL_LAT - 1;
    if (stall && m_stall < 65535) m_stall++;
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    chk("reset ctl", {8'h00, ctl}, 16'h001C);
    chk("reset stall_cnt", stall_cnt, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held ctl", {8'h00, ctl}, 16'h001C);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) do_cycle("init_to_run");

    set_in(6'd0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0);
    do_cycle("load_use");
    set_in(6'd0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    do_cycle("load_use_r0");
    set_in(6'd35, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    do_cycle("rt_not_source");
    idle();
    do_cycle("after_lu");

    set_in(6'd0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
    do_cycle("maddu_start");
    idle();
    for (int i = 0; i < 5; i++) do_cycle("maddu_wait");

    set_in(6'd0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
    do_cycle("abort_start");
    idle();
    do_cycle("abort_wait1");
    set_in(6'd0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1);
    do_cycle("abort_branch");
    idle();
    for (int i = 0; i < 3; i++) do_cycle("after_abort");

    set_in(6'd0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1);
    do_cycle("all_events");
    idle();
    for (int i = 0; i < 3; i++) do_cycle("after_all");

    for (int i = 0; i < 2000; i++) begin
      set_in(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 7) == 0));
      do_cycle("random");
    end
    idle();
    for (int i = 0; i < 4; i++) do_cycle("drain");

    set_in(6'd0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) do_cycle("saturate");
    chk("sat_hold", stall_cnt, 16'hFFFF);
    idle();
    do_cycle("sat_idle");

    set_in(6'd0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0);
    do_cycle("rst_mul_start");
    idle();
    do_cycle("rst_mul_wait1");
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_mul ctl", {8'h00, ctl}, 16'h001C);
    chk("rst_mid_mul stall_cnt", stall_cnt, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) do_cycle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
